// File: rtl/iterative_normalizer.sv
// -----------------------------------------------------------------------------
// iterative_normalizer
//   Left-shifts a word one bit per cycle until it is normalized and reports how
//   many shifts were applied. A downstream barrel shifter can then undo the
//   operation.
//
//   Normalized means:
//     unsigned: the MSB is set (leading-zero normalize)
//     signed  : the top two bits differ (leading-sign normalize)
//   An all-zero word exits on the first SHIFT cycle with out_zero set.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_valid     in_data / in_signed are valid
//   in_ready     block can accept a word (IDLE only)
//   in_data      word to normalize
//   in_signed    0 = unsigned normalize, 1 = signed normalize
//   out_valid    result valid (DONE only)
//   out_ready    consumer accepts the result
//   out_data     normalized word
//   out_shift    number of left shifts applied
//   out_zero     input word was all zeros
//
// Parameters:
//   WIDTH >= 2; SHW must satisfy 2**SHW >= WIDTH so the count never wraps.
// -----------------------------------------------------------------------------
module iterative_normalizer #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shift,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             sgn;
    logic [SHW-1:0]   cnt;

    logic normalized;
    logic work_zero;

    assign normalized = sgn ? (work[WIDTH-1] ^ work[WIDTH-2]) : work[WIDTH-1];
    assign work_zero  = (work == '0);

    // Handshake flags are registered alongside the state so they change
    // exactly with state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            sgn       <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        sgn      <= in_signed;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (normalized || work_zero) begin
                        out_data  <= work;
                        out_shift <= cnt;
                        out_zero  <= work_zero;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // Nonzero words normalize within WIDTH-1 shifts, so
                        // cnt stays in range.
                        work <= {work[WIDTH-2:0], 1'b0};
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Results stay on out_* after the handoff.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
